shifter_arbiter: RTL and testbench
==================================

SHIFTER_ARBITER -- requirements
Module: shifter_arbiter

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 reqN_valid  input  1  (N=0,1) requester N presents a shift request.
REQ-004 reqN_ready  output  1  (N=0,1) request N accepted this cycle when reqN_valid&reqN_ready.
REQ-005 reqN_data  input  32  (N=0,1) operand.
REQ-006 reqN_op  input  3  (N=0,1) 000 pass, 001 LSR, 010 LSL, 011 ROR, 100 ASR, 101 ASL, 110/111 illegal.
REQ-007 reqN_cnt  input  5  (N=0,1) shift amount 0..31.
REQ-008 rsp_valid  output  1  result register holds an unconsumed result.
REQ-009 rsp_ready  input  1  consumer accepts result when rsp_valid&rsp_ready.
REQ-010 rsp_id  output  1  index of requester that issued the held result.
REQ-011 rsp_data  output  32  shift result.
REQ-012 rsp_err  output  1  held request used an illegal op.

Function
REQ-013 Block SHALL contain exactly one instance of the team's barrel shifter, fed by a grant mux selecting req0 or req1 fields.
REQ-014 FSM states: IDLE (result register empty), HOLD (result register full).
REQ-015 IDLE: reqN_ready=1 only for the granted requester; at most one ready high per cycle.
REQ-016 Grant: single valid requester wins; both valid -> requester not granted last (round-robin pointer last_grant).
REQ-017 On accept: next cycle rsp_valid=1, rsp_id=grant, rsp_data=shifter output, FSM -> HOLD; latency exactly 1 cycle.
REQ-018 last_grant updates only on an accepted request, never on mere valid.
REQ-019 HOLD: rsp_data, rsp_id, rsp_err stable until handshake; a stalled rsp_ready SHALL NOT lose or alter the result.
REQ-020 HOLD with rsp_ready=1 -> IDLE next cycle (unless REQ-028 applies).
REQ-021 Op semantics: ROR with cnt=0 returns data unchanged; ASR sign-fills from bit 31; ASL equals LSL; cnt=0 returns data for every legal op.
REQ-022 Illegal op (110/111): request accepted normally, rsp_data=32'h0, rsp_err=1; never X.
REQ-023 rsp_err=0 for all legal ops.
REQ-024 Requester inputs SHALL be sampled only in the accept cycle; changes after accept have no effect.

Reset
REQ-025 rst=1: FSM=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, last_grant=1 (req0 wins first conflict).
REQ-026 rst mid-HOLD discards held result; no response issued for it.
REQ-027 During rst cycle reqN_ready=0 for both N.

Configuration
REQ-028 Macro SHIFTER_ARB_PIPE_EN defined: in HOLD with rsp_ready=1, arbiter also grants/accepts a new request same cycle; result register reloads, FSM stays HOLD, throughput 1 result/cycle.
REQ-029 SHIFTER_ARB_PIPE_EN undefined: reqN_ready=0 in HOLD; one bubble cycle between consecutive results (max 1 result per 2 cycles).

Verification
REQ-030 req0 only: data=32'h8000_0001, op=011, cnt=1 -> one cycle later rsp_valid=1, rsp_id=0, rsp_data=32'hC000_0000, rsp_err=0.
REQ-031 Both valid for 4 cycles after reset, rsp_ready=1 -> grant order 0,1,0,1; req1 op=100, data=32'hF000_0000, cnt=4 -> rsp_data=32'hFF00_0000.
REQ-032 rsp_ready=0 for 5 cycles in HOLD, req1 valid -> rsp_data unchanged, req1_ready=0 throughout, no new accept until handshake.
REQ-033 req0 op=111, data=32'h1234_5678 -> rsp_data=32'h0, rsp_err=1; following legal request op=010 cnt=4 data=32'h1 -> rsp_data=32'h10, rsp_err=0.
REQ-034 rst asserted while HOLD -> next cycle rsp_valid=0, last_grant=1; both valid afterwards -> req0 granted.
REQ-035 Continuous req0 stream, rsp_ready=1 -> with SHIFTER_ARB_PIPE_EN rsp_valid high every cycle; without it, rsp_valid alternates 1,0.

Source files
------------

// File: rtl/shifter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shifter_arbiter
// Brief    : Two-requester round-robin front end sharing one barrel shifter,
//            with a single-entry result register. Macro SHIFTER_ARB_PIPE_EN
//            enables back-to-back accepts while the result is being drained.
// Revision : 1.0 - initial release
// ============================================================================

module shifter_arbiter_barrel (
    input  logic [31:0] data_i,
    input  logic [2:0]  op_i,
    input  logic [4:0]  cnt_i,
    output logic [31:0] data_o,
    output logic        err_o
);
    localparam logic [2:0] c_OP_PASS = 3'b000;
    localparam logic [2:0] c_OP_LSR  = 3'b001;
    localparam logic [2:0] c_OP_LSL  = 3'b010;
    localparam logic [2:0] c_OP_ROR  = 3'b011;
    localparam logic [2:0] c_OP_ASR  = 3'b100;
    localparam logic [2:0] c_OP_ASL  = 3'b101;

    logic [31:0] w_lsr;
    logic [31:0] w_lsl;
    logic [31:0] w_ror;
    logic [31:0] w_asr;

    always_comb begin
        w_lsr = data_i >> cnt_i;
        w_lsl = data_i << cnt_i;
        // A shift by the full width yields zero, so cnt=0 rotates to data unchanged.
        w_ror = (data_i >> cnt_i) | (data_i << (6'd32 - {1'b0, cnt_i}));
        w_asr = $unsigned($signed(data_i) >>> cnt_i);
        data_o = '0;
        err_o  = 1'b0;
        case (op_i)
            c_OP_PASS: data_o = data_i;
            c_OP_LSR:  data_o = w_lsr;
            c_OP_LSL:  data_o = w_lsl;
            c_OP_ROR:  data_o = w_ror;
            c_OP_ASR:  data_o = w_asr;
            c_OP_ASL:  data_o = w_lsl;
            default: begin
                data_o = '0;
                err_o  = 1'b1;
            end
        endcase
    end
endmodule

module shifter_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [2:0]  req0_op,
    input  logic [4:0]  req0_cnt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [2:0]  req1_op,
    input  logic [4:0]  req1_cnt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    logic [0:0]  state_q;
    logic [0:0]  state_d;
    logic        last_grant_q;
    logic        rsp_id_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;

    logic        w_grant;
    logic        w_rsp_fire;
    logic        w_can_accept;
    logic        w_accept;
    logic [31:0] w_sel_data;
    logic [2:0]  w_sel_op;
    logic [4:0]  w_sel_cnt;
    logic [31:0] w_sh_data;
    logic        w_sh_err;

    // Conflict goes to the requester not served last; otherwise the lone valid one.
    always_comb begin
        if (req0_valid && req1_valid) begin
            w_grant = ~last_grant_q;
        end else begin
            w_grant = req1_valid;
        end
    end

    always_comb begin
        w_rsp_fire = (state_q == c_ST_HOLD) && rsp_ready;
`ifdef SHIFTER_ARB_PIPE_EN
        w_can_accept = !rst && ((state_q == c_ST_IDLE) || w_rsp_fire);
`else
        w_can_accept = !rst && (state_q == c_ST_IDLE);
`endif
        w_accept   = w_can_accept && (w_grant ? req1_valid : req0_valid);
        w_sel_data = w_grant ? req1_data : req0_data;
        w_sel_op   = w_grant ? req1_op   : req0_op;
        w_sel_cnt  = w_grant ? req1_cnt  : req0_cnt;
    end

    shifter_arbiter_barrel u_barrel (
        .data_i (w_sel_data),
        .op_i   (w_sel_op),
        .cnt_i  (w_sel_cnt),
        .data_o (w_sh_data),
        .err_o  (w_sh_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (w_accept) state_d = c_ST_HOLD;
            c_ST_HOLD: if (w_rsp_fire) state_d = w_accept ? c_ST_HOLD : c_ST_IDLE;
            default:   state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid  = (state_q == c_ST_HOLD);
        req0_ready = w_can_accept && !w_grant;
        req1_ready = w_can_accept && w_grant;
    end

    // The result register only loads on accept, so a stalled consumer sees it frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else if (w_accept) begin
            last_grant_q <= w_grant;
            rsp_id_q     <= w_grant;
            rsp_data_q   <= w_sh_data;
            rsp_err_q    <= w_sh_err;
        end
    end

    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
endmodule

`default_nettype wire

// File: tb/tb_shifter_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shifter_arbiter
// Brief    : Self-checking bench for shifter_arbiter with a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_shifter_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic [2:0]  req0_op, req1_op;
    logic [4:0]  req0_cnt, req1_cnt;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_data;

    int          errors = 0;
    int          checks = 0;
    logic [33:0] sb[$];

    always #5 clk = ~clk;

    shifter_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_op    (req0_op),
        .req0_cnt   (req0_cnt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_op    (req1_op),
        .req1_cnt   (req1_cnt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    // Bit-by-bit reference model: returns {err, data}.
    function automatic logic [32:0] model_shift(input logic [31:0] d, input logic [2:0] op,
                                                input logic [4:0] c);
        logic [31:0] r;
        logic        e;
        int          s;
        r = '0;
        e = 1'b0;
        s = int'(c);
        for (int i = 0; i < 32; i++) begin
            case (op)
                3'b000:         r[i] = d[i];
                3'b001:         r[i] = (i + s < 32) ? d[i + s] : 1'b0;
                3'b010, 3'b101: r[i] = (i >= s) ? d[i - s] : 1'b0;
                3'b011:         r[i] = d[(i + s) % 32];
                3'b100:         r[i] = (i + s < 32) ? d[i + s] : d[31];
                default: begin
                    r[i] = 1'b0;
                    e    = 1'b1;
                end
            endcase
        end
        return {e, r};
    endfunction

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        logic [33:0] exp_e;
        logic [32:0] m;
        if (rst) begin
            sb.delete();
        end else begin
            checks++;
            if (req0_ready && req1_ready) begin
                errors++;
                $display("FAIL onehot_ready: ready0=%b ready1=%b, required at most one high",
                         req0_ready, req1_ready);
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: id=%0d data=%h with no pending request",
                             rsp_id, rsp_data);
                end else begin
                    exp_e = sb.pop_front();
                    if ({rsp_id, rsp_err, rsp_data} !== exp_e) begin
                        errors++;
                        $display("FAIL rsp_compare: got id=%b err=%b data=%h, required id=%b err=%b data=%h",
                                 rsp_id, rsp_err, rsp_data, exp_e[33], exp_e[32], exp_e[31:0]);
                    end
                end
            end
            if (req0_valid && req0_ready) begin
                m = model_shift(req0_data, req0_op, req0_cnt);
                sb.push_back({1'b0, m});
            end else if (req1_valid && req1_ready) begin
                m = model_shift(req1_data, req1_op, req1_cnt);
                sb.push_back({1'b1, m});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!rsp_valid && sb.size() == 0) break;
        end
        checks++;
        if (rsp_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: rsp_valid=%b pending=%0d, required 0 and 0",
                     rsp_valid, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        req0_data = 32'h1; req0_op = 3'b000; req0_cnt = 5'd0;
        req1_data = 32'h2; req1_op = 3'b000; req1_cnt = 5'd0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b id=%b err=%b data=%h, required all zero",
                     rsp_valid, rsp_id, rsp_err, rsp_data);
        end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: ready0=%b ready1=%b, required 0 0", req0_ready, req1_ready);
        end
        tick();
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_ror();
        req0_valid = 1'b1; req0_data = 32'h8000_0001; req0_op = 3'b011; req0_cnt = 5'd1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL ror_ready: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0; req0_data = 32'hDEAD_BEEF; req0_op = 3'b010; req0_cnt = 5'd7;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b100, 32'hC000_0000}) begin
            errors++;
            $display("FAIL ror_latency: valid=%b id=%b err=%b data=%h, required 1 0 0 c0000000",
                     rsp_valid, rsp_id, rsp_err, rsp_data);
        end
        drain();
    endtask

    task automatic test_round_robin();
        int got[$];
        bit seen_ff = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_data = 32'h0000_0011; req0_op = 3'b010; req0_cnt = 5'd1;
        req1_valid = 1'b1; req1_data = 32'hF000_0000; req1_op = 3'b100; req1_cnt = 5'd4;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) got.push_back(0);
            else if (req1_valid && req1_ready) got.push_back(1);
            if (rsp_valid && rsp_id && !seen_ff) begin
                seen_ff = 1'b1;
                checks++;
                if (rsp_data !== 32'hFF00_0000) begin
                    errors++;
                    $display("FAIL rr_asr_data: got %h, required ff000000", rsp_data);
                end
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (got.size() != 4 || got[0] != 0 || got[1] != 1 || got[2] != 0 || got[3] != 1) begin
            errors++;
            $display("FAIL rr_order: got %0d grants %0d,%0d,%0d,%0d, required 4 grants 0,1,0,1",
                     got.size(), got[0], got[1], got[2], got[3]);
        end
        checks++;
        if (!seen_ff) begin
            errors++;
            $display("FAIL rr_req1_rsp: got no req1 response, required one");
        end
        drain();
    endtask

    task automatic test_stall();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 32'h0000_00F0; req0_op = 3'b001; req0_cnt = 5'd4;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 32'h0000_0003; req1_op = 3'b010; req1_cnt = 5'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, req1_ready} !== {2'b10, 32'h0000_000F, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold: valid=%b id=%b data=%h ready1=%b, required 1 0 0000000f 0",
                         rsp_valid, rsp_id, rsp_data, req1_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
`ifdef SHIFTER_ARB_PIPE_EN
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: ready1=%b, required 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
`else
        if (req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_release_ready: ready1=%b, required 0", req1_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_idle_ready: ready1=%b, required 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
`endif
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {2'b11, 32'h0000_000C}) begin
            errors++;
            $display("FAIL stall_next_rsp: valid=%b id=%b data=%h, required 1 1 0000000c",
                     rsp_valid, rsp_id, rsp_data);
        end
        drain();
    endtask

    task automatic test_illegal();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 32'h1234_5678; req0_op = 3'b111; req0_cnt = 5'd3;
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b101, 32'h0}) begin
            errors++;
            $display("FAIL illegal_op: valid=%b id=%b err=%b data=%h, required 1 0 1 00000000",
                     rsp_valid, rsp_id, rsp_err, rsp_data);
        end
        tick();
        req0_valid = 1'b1; req0_data = 32'h0000_0001; req0_op = 3'b010; req0_cnt = 5'd4;
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b100, 32'h0000_0010}) begin
            errors++;
            $display("FAIL legal_after_illegal: valid=%b id=%b err=%b data=%h, required 1 0 0 00000010",
                     rsp_valid, rsp_id, rsp_err, rsp_data);
        end
        tick();
        req1_valid = 1'b1; req1_data = 32'h0000_FFFF; req1_op = 3'b110; req1_cnt = 5'd0;
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b111, 32'h0}) begin
            errors++;
            $display("FAIL illegal_op110: valid=%b id=%b err=%b data=%h, required 1 1 1 00000000",
                     rsp_valid, rsp_id, rsp_err, rsp_data);
        end
        drain();
    endtask

    task automatic test_reset_hold();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 32'h0000_0005; req0_op = 3'b000; req0_cnt = 5'd0;
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsthold_pre: rsp_valid=%b, required 1", rsp_valid);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== 34'h0) begin
            errors++;
            $display("FAIL rsthold_discard: valid=%b err=%b data=%h, required 0 0 00000000",
                     rsp_valid, rsp_err, rsp_data);
        end
        tick();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 32'h0000_0100; req0_op = 3'b001; req0_cnt = 5'd8;
        req1_valid = 1'b1; req1_data = 32'h0000_0100; req1_op = 3'b010; req1_cnt = 5'd8;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rsthold_grant: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
        end
        tick();
        drain();
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        tick();
        rsp_ready = 1'b1;
        req0_valid = 1'b1;
        req0_data = $urandom; req0_op = 3'($urandom_range(0, 7)); req0_cnt = 5'($urandom_range(0, 31));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i >= 1) begin
`ifdef SHIFTER_ARB_PIPE_EN
                exp_v = 1'b1;
`else
                exp_v = (i % 2 == 1);
`endif
                checks++;
                if (rsp_valid !== exp_v) begin
                    errors++;
                    $display("FAIL b2b_valid[%0d]: rsp_valid=%b, required %b", i, rsp_valid, exp_v);
                end
            end
            tick();
            req0_data = $urandom; req0_op = 3'($urandom_range(0, 7));
            req0_cnt = 5'($urandom_range(0, 31));
        end
        drain();
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_data = '0; req0_op = '0; req0_cnt = '0;
        req1_data = '0; req1_op = '0; req1_cnt = '0;
        test_reset();
        test_ror();
        test_round_robin();
        test_stall();
        test_illegal();
        test_reset_hold();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d responses outstanding, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
